conv_encoder: RTL and testbench
===============================

CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, information bits per frame (legal 1..255).
REQ-002 SHALL have parameter CNT_W, default 8, width of the frame bit counter.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  frame start request, sampled only in IDLE.
REQ-006 SHALL have port in_valid  input  1  in_bit valid.
REQ-007 SHALL have port in_bit  input  1  information bit.
REQ-008 SHALL have port in_ready  output  1  encoder accepts in_bit this cycle.
REQ-009 SHALL have port sym_ready  input  1  downstream (channel/decoder dec_in side) accepts symbol.
REQ-010 SHALL have port sym_valid  output  1  sym_out holds a valid symbol.
REQ-011 SHALL have port sym_out  output  2  coded symbol {g0,g1}, matching the decoder's 2-bit dec_in.
REQ-012 SHALL have port enc_state  output  2  shift register {s1,s0}, trellis state index.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 SHALL implement rate-1/2, K=3 code, generators 7,5 octal: sym_out[1]=b^s0^s1, sym_out[0]=b^s1; next {s1,s0}={s0,b}; s0 = most recent bit.
REQ-016 SHALL implement FSM states IDLE, DATA, TAIL, DRAIN.
REQ-017 IDLE: start=1 -> DATA, same edge clears enc_state to 00 and counter to 0; start ignored in all other states.
REQ-018 in_ready SHALL equal (state==DATA) && (!sym_valid || sym_ready); combinational.
REQ-019 Input accepted on edge with in_valid && in_ready: encoded symbol loaded into output register, sym_valid=1 next cycle (latency 1 clk), enc_state updated, counter incremented.
REQ-020 Acceptance of bit number FRAME_LEN (counter == FRAME_LEN-1) SHALL move DATA -> TAIL.
REQ-021 TAIL: encode two zero bits, each loaded when (!sym_valid || sym_ready), one per cycle max; after second tail load -> DRAIN; enc_state returns to 00.
REQ-022 DRAIN: when sym_valid && sym_ready (last tail symbol taken) -> IDLE with frame_done=1 for exactly that cycle following the transfer.
REQ-023 sym_out/sym_valid SHALL hold stable while sym_valid && !sym_ready; no symbol dropped or duplicated.
REQ-024 Symbol transfer and new load on same edge (sym_ready=1, new input) SHALL keep sym_valid=1 with new symbol; back-to-back throughput 1 symbol/clk.
REQ-025 Symbol transfer with no new load SHALL clear sym_valid next edge.
REQ-026 in_valid while not in DATA SHALL be ignored (in_ready=0).
REQ-027 Frame SHALL emit exactly FRAME_LEN+2 symbols; counter never wraps within a frame.
REQ-028 FRAME_LEN=1 SHALL go DATA -> TAIL after the first accepted bit.
REQ-029 start asserted on the frame_done cycle SHALL be accepted (IDLE reached that edge, sampled next edge).

Reset
REQ-030 rst=0 SHALL immediately force: state IDLE, enc_state 00, counter 0, sym_valid 0, sym_out 00, frame_done 0, busy 0, in_ready 0.
REQ-031 Reset mid-frame SHALL discard the pending symbol and partial frame; no frame_done pulse.
REQ-032 After rst deasserts, no activity until start.

Verification
REQ-033 FRAME_LEN=4, start, bits 1,0,1,1, sym_ready=1 -> sym_out 11,10,00,01,01,11 on consecutive cycles, then frame_done pulse, enc_state 00.
REQ-034 Same frame with sym_ready=0 for 3 cycles after first symbol -> sym_out held at 11, in_ready=0, sequence unchanged after release.
REQ-035 in_valid toggled 1/0 each cycle -> gaps in sym_valid, symbols still 11,10,00,01,01,11, exactly 6 transfers.
REQ-036 rst=0 after second symbol -> sym_valid, busy, enc_state 00 same cycle; new start then bits 1,0,1,1 reproduce REQ-033 output.
REQ-037 start pulsed during DATA and TAIL -> no effect; start on frame_done cycle -> next frame begins with enc_state 00.
REQ-038 FRAME_LEN=1, bit 1 -> symbols 11,10,11, frame_done after third transfer.

Source files
------------

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 (7,5 octal) convolutional encoder with frame sequencing, zero-tail
// termination and a one-deep valid/ready symbol output register.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// DATA  | accepting FRAME_LEN information bits
// TAIL  | flushing two zero bits to return the trellis to state 00
// DRAIN | waiting for the last tail symbol to be taken
module conv_encoder #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  input  logic       sym_ready,
  output logic       sym_valid,
  output logic [1:0] sym_out,
  output logic [1:0] enc_state,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_e;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [1:0]       sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tail_q, tail_d;
  logic             sym_valid_q, sym_valid_d;
  logic [1:0]       sym_q, sym_d;
  logic             done_q, done_d;

  logic slot_free;
  logic accept;
  logic load;
  logic code_bit;

  assign slot_free = !sym_valid_q || sym_ready;
  assign in_ready  = (state_q == DATA) && slot_free;
  assign accept    = in_ready && in_valid;
  assign load      = accept || ((state_q == TAIL) && slot_free);
  // tail bits are zeros
  assign code_bit  = (state_q == DATA) ? in_bit : 1'b0;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    tail_d      = tail_q;
    sym_valid_d = sym_valid_q;
    sym_d       = sym_q;
    done_d      = 1'b0;

    if (sym_valid_q && sym_ready) begin
      sym_valid_d = 1'b0;
    end

    // sreg = {s1,s0}; s0 is the most recent bit
    if (load) begin
      sym_d       = {code_bit ^ sreg_q[0] ^ sreg_q[1], code_bit ^ sreg_q[1]};
      sym_valid_d = 1'b1;
      sreg_d      = {sreg_q[0], code_bit};
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DATA;
          sreg_d  = 2'b00;
          cnt_d   = '0;
          tail_d  = 1'b0;
        end
      end
      DATA: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = TAIL;
            tail_d  = 1'b0;
          end
        end
      end
      TAIL: begin
        if (slot_free) begin
          tail_d = 1'b1;
          if (tail_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (sym_valid_q && sym_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sreg_q      <= 2'b00;
      cnt_q       <= '0;
      tail_q      <= 1'b0;
      sym_valid_q <= 1'b0;
      sym_q       <= 2'b00;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      tail_q      <= tail_d;
      sym_valid_q <= sym_valid_d;
      sym_q       <= sym_d;
      done_q      <= done_d;
    end
  end

  assign sym_valid  = sym_valid_q;
  assign sym_out    = sym_q;
  assign enc_state  = sreg_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: directed and randomized frames on FRAME_LEN=4 and
// FRAME_LEN=1 instances, checked against a generator-polynomial reference model.
module tb_conv_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start, in_valid, in_bit, sym_ready;
  logic sel;

  logic       in_ready4, sym_valid4, busy4, done4;
  logic [1:0] sym_out4, enc_state4;
  logic       in_ready1, sym_valid1, busy1, done1;
  logic [1:0] sym_out1, enc_state1;

  logic       in_ready, sym_valid, busy, frame_done;
  logic [1:0] sym_out, enc_state;

  int checks = 0;
  int errors = 0;

  conv_encoder #(.FRAME_LEN(4), .CNT_W(8)) u_enc4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start && !sel),
    .in_valid  (in_valid && !sel),
    .in_bit    (in_bit),
    .in_ready  (in_ready4),
    .sym_ready (sym_ready),
    .sym_valid (sym_valid4),
    .sym_out   (sym_out4),
    .enc_state (enc_state4),
    .busy      (busy4),
    .frame_done(done4)
  );

  conv_encoder #(.FRAME_LEN(1), .CNT_W(8)) u_enc1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start && sel),
    .in_valid  (in_valid && sel),
    .in_bit    (in_bit),
    .in_ready  (in_ready1),
    .sym_ready (sym_ready),
    .sym_valid (sym_valid1),
    .sym_out   (sym_out1),
    .enc_state (enc_state1),
    .busy      (busy1),
    .frame_done(done1)
  );

  assign in_ready   = sel ? in_ready1  : in_ready4;
  assign sym_valid  = sel ? sym_valid1 : sym_valid4;
  assign sym_out    = sel ? sym_out1   : sym_out4;
  assign enc_state  = sel ? enc_state1 : enc_state4;
  assign busy       = sel ? busy1      : busy4;
  assign frame_done = sel ? done1      : done4;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Symbol n of a frame: information bits followed by two zeros, zero history before.
  // g0 = 1+D+D^2 (7), g1 = 1+D^2 (5).
  function automatic logic [1:0] model_sym(input logic [15:0] bits, input int flen, input int n);
    logic b0, b1, b2;
    b0 = (n < flen) ? bits[n] : 1'b0;
    b1 = (n >= 1 && n - 1 < flen) ? bits[n-1] : 1'b0;
    b2 = (n >= 2 && n - 2 < flen) ? bits[n-2] : 1'b0;
    return {b0 ^ b1 ^ b2, b0 ^ b2};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_bit = 1'($urandom); sym_ready = 1'b1;
      #1;
      chk("idle_in_ready", 8'(in_ready), 8'd0);
      @(posedge clk); #1;
      chk("idle_busy", 8'(busy), 8'd0);
      chk("idle_valid", 8'(sym_valid), 8'd0);
      chk("idle_done", 8'(frame_done), 8'd0);
    end
    in_valid = 1'b0;
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random. rmode: 0 always ready,
  // 1 three-cycle stall after first symbol, 2 random.
  task automatic run_frame(input int flen, input logic [15:0] bits, input int vmode,
                           input int rmode, input bit poke, input int abort_after);
    int idx = 0, nx = 0, cyc = 0, first_v = -1;
    int total = flen + 2;
    bit holding = 1'b0, xfer, acc;
    logic [1:0] hold_sym, pre_sym;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; sym_ready = 1'b0;
    @(posedge clk); #1;
    chk("start_busy", 8'(busy), 8'd1);
    chk("start_state", 8'(enc_state), 8'd0);
    chk("start_valid", 8'(sym_valid), 8'd0);
    start = 1'b0;
    while (nx < total && cyc < 400) begin
      @(negedge clk);
      case (vmode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom);
      endcase
      in_bit = (idx < flen) ? bits[idx] : 1'($urandom);
      if (first_v < 0 && sym_valid) first_v = cyc;
      case (rmode)
        0: sym_ready = 1'b1;
        1: sym_ready = !(first_v >= 0 && cyc < first_v + 3);
        default: sym_ready = 1'($urandom);
      endcase
      start = poke ? 1'($urandom) : 1'b0;
      #1;
      if (holding) begin
        chk("hold_valid", 8'(sym_valid), 8'd1);
        chk("hold_sym", 8'(sym_out), 8'(hold_sym));
      end
      chk("in_ready", 8'(in_ready), 8'((idx < flen) && (!sym_valid || sym_ready)));
      xfer = sym_valid && sym_ready;
      acc = in_valid && in_ready;
      pre_sym = sym_out;
      holding = sym_valid && !sym_ready;
      hold_sym = sym_out;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
      if (xfer) begin
        chk($sformatf("sym%0d", nx), 8'(pre_sym), 8'(model_sym(bits, flen, nx)));
        nx++;
        if (abort_after > 0 && nx == abort_after) begin
          start = 1'b0;
          return;
        end
      end
      if (nx < total) chk("early_done", 8'(frame_done), 8'd0);
    end
    start = 1'b0; in_valid = 1'b0;
    chk("frame_timeout", 8'(cyc < 400), 8'd1);
    chk("done_pulse", 8'(frame_done), 8'd1);
    chk("end_busy", 8'(busy), 8'd0);
    chk("end_state", 8'(enc_state), 8'd0);
    chk("end_valid", 8'(sym_valid), 8'd0);
    chk("bits_taken", 8'(idx), 8'(flen));
  endtask

  initial begin
    logic [15:0] rbits;
    rst = 1'b0; sel = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; sym_ready = 1'b0;
    #12;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_valid", 8'(sym_valid), 8'd0);
    chk("rst_sym", 8'(sym_out), 8'd0);
    chk("rst_state", 8'(enc_state), 8'd0);
    chk("rst_in_ready", 8'(in_ready), 8'd0);
    chk("rst_done", 8'(frame_done), 8'd0);
    @(negedge clk); rst = 1'b1;
    idle(3);

    // bits 1,0,1,1 (bit0 first) -> 11,10,00,01,01,11
    run_frame(4, 16'h000D, 0, 0, 0, 0);
    idle(2);
    run_frame(4, 16'h000D, 0, 1, 0, 0);
    idle(1);
    run_frame(4, 16'h000D, 1, 0, 0, 0);
    idle(1);

    run_frame(4, 16'h000D, 0, 0, 0, 2);
    #2; rst = 1'b0; #1;
    chk("mid_rst_valid", 8'(sym_valid), 8'd0);
    chk("mid_rst_busy", 8'(busy), 8'd0);
    chk("mid_rst_state", 8'(enc_state), 8'd0);
    chk("mid_rst_in_ready", 8'(in_ready), 8'd0);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    idle(3);
    run_frame(4, 16'h000D, 0, 0, 0, 0);

    // start pokes inside the frame, then a start on the frame_done cycle
    run_frame(4, 16'($urandom), 2, 2, 1, 0);
    run_frame(4, 16'h000D, 0, 0, 0, 0);
    idle(1);

    sel = 1'b1;
    idle(1);
    run_frame(1, 16'h0001, 0, 0, 0, 0);
    run_frame(1, 16'h0000, 2, 2, 1, 0);
    idle(1);
    sel = 1'b0;
    idle(1);

    for (int f = 0; f < 12; f++) begin
      rbits = 16'($urandom);
      run_frame(4, rbits, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
